instruction_fetch_unit: RTL and testbench

Fetch stage feeding the instruction decode unit. Holds the program counter, and issues one word read per instruction to instruction memory over a req/ack handshake. Presents the fetched word with `Fetch_ready` and holds it until decode signals `IDU_ready`. Then advances the PC by the decoder's `pc_increment`, or by a control-unit redirect if one is pending.

---
 rtl/instruction_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word per instruction over a
// req/ack handshake, presents it to decode and advances the PC by the decoder
// increment or by a pending control-unit redirect.
// Optional feature: IFU_MISALIGN_TRAP_EN makes a misaligned PC fault in REQ
// instead of being silently aligned on mem_addr.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        soc_clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] instruction,
  output logic        Fetch_ready,
  input  logic        IDU_ready,
  input  logic [31:0] pc_increment,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic        fetch_fault,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ADVANCE,
    S_HALT
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic        redir_pend;
  logic [31:0] redir_tgt;
  logic        halt_pend;
  logic        timeout_hit;
  logic        misalign_hit;
  logic [31:0] next_pc;

`ifdef IFU_MISALIGN_TRAP_EN
  assign mem_addr = pc;
`else
  assign mem_addr = {pc[31:2], 2'b00};
`endif

  // State register
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and per-state outputs
  always_comb begin
    state_next   = state;
    mem_req      = 1'b0;
    Fetch_ready  = 1'b0;
    halted       = 1'b0;
    timeout_hit  = 1'b0;
    misalign_hit = 1'b0;
    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
`ifdef IFU_MISALIGN_TRAP_EN
        if (pc[1:0] != 2'b00) begin
          misalign_hit = 1'b1;
          state_next   = S_HALT;
        end else begin
          mem_req    = 1'b1;
          state_next = S_WAIT;
        end
`else
        mem_req    = 1'b1;
        state_next = S_WAIT;
`endif
      end
      S_WAIT: begin
        // An ack on the last allowed cycle still wins over the timeout
        if (mem_ack) begin
          state_next = S_HOLD;
        end else if (wait_cnt == LAST_WAIT) begin
          timeout_hit = 1'b1;
          state_next  = S_HALT;
        end
      end
      S_HOLD: begin
        Fetch_ready = 1'b1;
        if (IDU_ready) state_next = S_ADVANCE;
      end
      S_ADVANCE: state_next = (halt_pend || halt_req) ? S_HALT : S_REQ;
      S_HALT:    halted = 1'b1;
      default:   state_next = S_IDLE;
    endcase
  end

  // Redirect strobe in the ADVANCE cycle itself beats any older pending target
  always_comb begin
    next_pc = pc + pc_increment;
    if (redirect_valid)  next_pc = redirect_target;
    else if (redir_pend) next_pc = redir_tgt;
  end

  // PC, instruction latch, wait counter, pending flags and sticky fault
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      instruction <= '0;
      wait_cnt    <= '0;
      redir_pend  <= 1'b0;
      redir_tgt   <= '0;
      halt_pend   <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      halt_pend   <= halt_pend | halt_req;
      fetch_fault <= fetch_fault | timeout_hit | misalign_hit;

      if (state == S_REQ) wait_cnt <= '0;
      else if (state == S_WAIT && !mem_ack) wait_cnt <= wait_cnt + 8'd1;

      if (state == S_WAIT && mem_ack) instruction <= mem_rdata;

      if (state == S_ADVANCE) begin
        pc         <= next_pc;
        redir_pend <= 1'b0;
      end else if (state != S_HALT && redirect_valid) begin
        redir_pend <= 1'b1;
        redir_tgt  <= redirect_target;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by randomized fetches against a transaction-level PC model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam int unsigned TB_TIMEOUT  = 15;

  logic        soc_clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] instruction;
  logic        Fetch_ready;
  logic        IDU_ready = 1'b0;
  logic [31:0] pc_increment = 32'd4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        halt_req = 1'b0;
  logic [31:0] pc;
  logic        fetch_fault;
  logic        halted;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [31:0] mpc;
  logic [31:0] inc_tab [5] = '{32'd4, 32'hFFFF_FFF8, 32'd12, 32'h0000_0040, 32'hFFFF_FFFC};

  instruction_fetch_unit #(
    .RESET_PC   (TB_RESET_PC),
    .ACK_TIMEOUT(TB_TIMEOUT)
  ) dut (
    .soc_clk        (soc_clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .instruction    (instruction),
    .Fetch_ready    (Fetch_ready),
    .IDU_ready      (IDU_ready),
    .pc_increment   (pc_increment),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt_req       (halt_req),
    .pc             (pc),
    .fetch_fault    (fetch_fault),
    .halted         (halted)
  );

  always #5 soc_clk = ~soc_clk;

  task automatic tick();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Next PC from the architectural rule: the latest redirect strobe seen
  // since the last advance wins, otherwise pc + increment modulo 2^32.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] inc,
                                             input int r1, input logic [31:0] t1,
                                             input int r2, input logic [31:0] t2);
    if (r1 < 0 && r2 < 0) return cur + inc;
    if (r2 >= r1) return t2;
    return t1;
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    mem_ack = 1'b0;
    IDU_ready = 1'b0;
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    #1;
    check("rst_pc", pc, TB_RESET_PC);
    check("rst_instr", instruction, 32'h0);
    check("rst_fetch_ready", {31'd0, Fetch_ready}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, align(TB_RESET_PC));
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
  endtask

  // One full instruction from the REQ cycle through ADVANCE. Redirect strobes
  // are placed at window cycle offsets (0 = first WAIT cycle, -1 = none).
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                          input int unsigned ack_dly, input int unsigned idu_dly,
                          input logic [31:0] inc,
                          input int r1_at, input logic [31:0] r1_tgt,
                          input int r2_at, input logic [31:0] r2_tgt,
                          input bit do_halt);
    int unsigned waited;
    int k;
    waited = 0;
    pc_increment = inc;
    while (mem_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check("req_latency", waited, 0);
    check("mem_addr", mem_addr, exp_addr);
    k = 0;
    tick();
    for (int unsigned i = 0; i <= ack_dly; i++) begin
      check("wait_no_fr", {31'd0, Fetch_ready}, 32'd0);
      check("wait_no_req", {31'd0, mem_req}, 32'd0);
      redirect_valid  = (k == r1_at) || (k == r2_at);
      redirect_target = (k == r2_at) ? r2_tgt : (k == r1_at) ? r1_tgt : $urandom();
      IDU_ready = 1'($urandom_range(0, 1));
      mem_ack   = (i == ack_dly);
      mem_rdata = (i == ack_dly) ? data : $urandom();
      tick();
      k++;
    end
    mem_ack = 1'b0;
    check("hold_fr", {31'd0, Fetch_ready}, 32'd1);
    check("hold_instr", instruction, data);
    for (int unsigned j = 0; j <= idu_dly; j++) begin
      redirect_valid  = (k == r1_at) || (k == r2_at);
      redirect_target = (k == r2_at) ? r2_tgt : (k == r1_at) ? r1_tgt : $urandom();
      halt_req  = do_halt && (j == 0);
      IDU_ready = (j == idu_dly);
      mem_ack   = (j == 0);
      mem_rdata = ~data;
      tick();
      k++;
      mem_ack = 1'b0;
      if (j < idu_dly) begin
        check("hold_fr_stay", {31'd0, Fetch_ready}, 32'd1);
        check("hold_instr_stable", instruction, data);
      end
    end
    halt_req = 1'b0;
    check("adv_fr_low", {31'd0, Fetch_ready}, 32'd0);
    check("adv_instr", instruction, data);
    redirect_valid  = (k == r1_at) || (k == r2_at);
    redirect_target = (k == r2_at) ? r2_tgt : (k == r1_at) ? r1_tgt : $urandom();
    IDU_ready = 1'($urandom_range(0, 1));
    tick();
    redirect_valid = 1'b0;
    IDU_ready = 1'b0;
    check("post_adv_halted", {31'd0, halted}, {31'd0, do_halt});
  endtask

  initial begin
    int unsigned ack, idu, w;
    int r1, r2;
    logic [31:0] t1, t2, inc, exp_addr;

    #2;
    // Reset release and first-word latency
    apply_reset();
    check("idle_no_req", {31'd0, mem_req}, 32'd0);
    tick();
    mpc = TB_RESET_PC;
    do_fetch(align(mpc), 32'h0050_0093, 0, 0, 32'd4, -1, '0, -1, '0, 0);
    mpc = model_next(mpc, 32'd4, -1, '0, -1, '0);

    // Sequential words
    for (int n = 0; n < 2; n++) begin
      do_fetch(align(mpc), $urandom(), 0, 1, 32'd4, -1, '0, -1, '0, 0);
      mpc = mpc + 32'd4;
    end

    // Redirect in WAIT overrides a -8 increment
    do_fetch(align(mpc), $urandom(), 1, 1, 32'hFFFF_FFF8, 0, 32'h100, -1, '0, 0);
    mpc = 32'h100;
    // Second strobe in HOLD replaces the first
    do_fetch(align(mpc), $urandom(), 1, 1, 32'hFFFF_FFF8, 0, 32'h100, 3, 32'h200, 0);
    mpc = 32'h200;
    // Strobe in the ADVANCE cycle itself, landing on the top word
    do_fetch(align(mpc), $urandom(), 0, 0, 32'd4, -1, '0, 2, 32'hFFFF_FFFC, 0);
    mpc = 32'hFFFF_FFFC;
    // Wrap-around
    do_fetch(align(mpc), $urandom(), 0, 0, 32'd4, -1, '0, -1, '0, 0);
    mpc = mpc + 32'd4;
    check("wrap_model", mpc, 32'h0);

    // Misaligned increment
    do_fetch(align(mpc), $urandom(), 0, 0, 32'd6, -1, '0, -1, '0, 0);
`ifdef IFU_MISALIGN_TRAP_EN
    check("trap_no_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("trap_fault", {31'd0, fetch_fault}, 32'd1);
    check("trap_halted", {31'd0, halted}, 32'd1);
    apply_reset();
    tick();
    mpc = TB_RESET_PC;
`else
    mpc = mpc + 32'd6;
    do_fetch(align(mpc), $urandom(), 0, 0, 32'd4, -1, '0, -1, '0, 0);
    mpc = mpc + 32'd4;
`endif

    // Randomized fetches, including an ack on the last allowed WAIT cycle
    for (int n = 0; n < 30; n++) begin
      ack = (n == 10) ? TB_TIMEOUT - 1 : $urandom_range(0, 4);
      idu = $urandom_range(0, 3);
      inc = inc_tab[$urandom_range(0, 4)];
      w = ack + idu + 3;
      r1 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, w - 1)) : -1;
      r2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w - 1)) : -1;
      t1 = $urandom();
      t1 = align(t1);
      t2 = $urandom();
      t2 = align(t2);
      exp_addr = align(mpc);
      do_fetch(exp_addr, $urandom(), ack, idu, inc, r1, t1, r2, t2, 0);
      mpc = model_next(mpc, inc, r1, t1, r2, t2);
      check("no_fault_run", {31'd0, fetch_fault}, 32'd0);
    end

    // Halt request during HOLD: handshake completes, then no more requests
    do_fetch(align(mpc), $urandom(), 1, 2, 32'd4, -1, '0, -1, '0, 1);
    for (int n = 0; n < 4; n++) begin
      tick();
      check("halt_no_req", {31'd0, mem_req}, 32'd0);
      check("halt_stays", {31'd0, halted}, 32'd1);
    end

    // Ack timeout
    apply_reset();
    tick();
    check("to_req", {31'd0, mem_req}, 32'd1);
    check("to_addr", mem_addr, align(TB_RESET_PC));
    for (int unsigned i = 1; i <= TB_TIMEOUT; i++) tick();
    check("to_edge_fault", {31'd0, fetch_fault}, 32'd0);
    check("to_edge_halted", {31'd0, halted}, 32'd0);
    tick();
    check("to_fault", {31'd0, fetch_fault}, 32'd1);
    check("to_halted", {31'd0, halted}, 32'd1);
    for (int n = 0; n < 4; n++) begin
      mem_ack = 1'b1;
      tick();
      check("to_no_req", {31'd0, mem_req}, 32'd0);
      check("to_fault_sticky", {31'd0, fetch_fault}, 32'd1);
    end
    mem_ack = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("to_rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("to_rst_halted", {31'd0, halted}, 32'd0);

    // Asynchronous reset while a word is held
    tick();
    reset = 1'b1;
    tick();
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'hAABB_CCDD;
    tick();
    mem_ack = 1'b0;
    check("mid_fr", {31'd0, Fetch_ready}, 32'd1);
    check("mid_instr", instruction, 32'hAABB_CCDD);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_fr", {31'd0, Fetch_ready}, 32'd0);
    check("mid_rst_instr", instruction, 32'h0);
    check("mid_rst_pc", pc, TB_RESET_PC);
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
